// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer bundle for sync_fifo.
//   master : drives wr_en, rd_en, d_in; observes full, empty, d_out
//   slave  : the FIFO side of the same signals
//   FIFO_STATUS_EN adds count/overflow/underflow (slave -> master).
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] d_in;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] d_out;
`ifdef FIFO_STATUS_EN
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output wr_en, rd_en, d_in,
    input  full, empty, d_out
`ifdef FIFO_STATUS_EN
    , input count, overflow, underflow
`endif
  );

  modport slave (
    input  wr_en, rd_en, d_in,
    output full, empty, d_out
`ifdef FIFO_STATUS_EN
    , output count, overflow, underflow
`endif
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH x WIDTH, registered read data.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (clears pointers and d_out)
//   bus  - sync_fifo_if.slave: wr_en/rd_en/d_in in, full/empty/d_out out
// Optional: define FIFO_STATUS_EN to add count, sticky overflow and
// sticky underflow to the bus.
// DEPTH must be a power of two >= 2 so the wrap bit scheme holds.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_d_out;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Extra MSB distinguishes a full lap from an empty FIFO.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Qualified against pre-edge flags; rst term keeps X requests during
  // reset from touching memory.
  assign w_wr_acc = bus.wr_en & ~w_full  & rst;
  assign w_rd_acc = bus.rd_en & ~w_empty & rst;

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= bus.d_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_d_out  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_acc) begin
        r_d_out  <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.d_out = r_d_out;

`ifdef FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.count     = r_wr_ptr - r_rd_ptr;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (8x8).
module tb_sync_fifo;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sync_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();
  sync_fifo #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] fill_v [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en = 1'b1; bus.d_in = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd();
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] exp;
    // Reset with X requests
    rst = 1'b0; bus.wr_en = 1'bx; bus.rd_en = 1'bx; bus.d_in = 8'hFF;
    repeat (3) cyc();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full",  bus.full,  0);
    chk("rst_dout",  bus.d_out, 8'h00);
`ifdef FIFO_STATUS_EN
    chk("rst_count", bus.count, 0);
    chk("rst_ovf",   bus.overflow, 0);
`endif
    // Read while empty
    rd();
    chk("uf_dout",  bus.d_out, 8'h00);
    chk("uf_empty", bus.empty, 1);
`ifdef FIFO_STATUS_EN
    chk("uf_sticky", bus.underflow, 1);
`endif

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      wr(fill_v[i]);
      chk("fill_empty", bus.empty, 0);
      chk("fill_full",  bus.full, (i == 7) ? 1 : 0);
      chk("fill_dout",  bus.d_out, 8'h00);
    end
    wr(8'h01);
    chk("ovf_full", bus.full, 1);
`ifdef FIFO_STATUS_EN
    chk("ovf_count",  bus.count, 8);
    chk("ovf_sticky", bus.overflow, 1);
`endif

    // Drain
    for (int i = 0; i < 8; i++) begin
      rd();
      chk("drain_dout",  bus.d_out, fill_v[i]);
      chk("drain_full",  bus.full, 0);
      chk("drain_empty", bus.empty, (i == 7) ? 1 : 0);
    end
    rd();
    chk("drain_hold",  bus.d_out, 8'h12);
    chk("drain_empty2", bus.empty, 1);

    // Wrap-around with 3 entries held
    for (int i = 0; i < 3; i++) begin
      wr(8'hE0 + 8'(i));
      q.push_back(8'hE0 + 8'(i));
    end
    bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.d_in = 8'h30 + 8'(i);
      cyc();
      exp = q.pop_front();
      q.push_back(8'h30 + 8'(i));
      chk("wrap_dout",  bus.d_out, exp);
      chk("wrap_empty", bus.empty, 0);
      chk("wrap_full",  bus.full, 0);
`ifdef FIFO_STATUS_EN
      chk("wrap_count", bus.count, 3);
`endif
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;

    // Fill to full, then simultaneous read+write
    for (int i = 0; i < 5; i++) begin
      wr(8'h50 + 8'(i));
      q.push_back(8'h50 + 8'(i));
    end
    chk("pre_sim_full", bus.full, 1);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.d_in = 8'hEE;
    cyc();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    exp = q.pop_front();
    chk("simf_dout", bus.d_out, exp);
    chk("simf_full", bus.full, 0);
`ifdef FIFO_STATUS_EN
    chk("simf_count", bus.count, 7);
`endif
    for (int i = 0; i < 7; i++) begin
      rd();
      exp = q.pop_front();
      chk("simf_drain", bus.d_out, exp);
    end
    chk("simf_empty", bus.empty, 1);

    // Simultaneous on empty: write only, no fall-through
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.d_in = 8'h77;
    cyc();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("sime_empty", bus.empty, 0);
    chk("sime_dout",  bus.d_out, exp);
`ifdef FIFO_STATUS_EN
    chk("sime_count", bus.count, 1);
`endif
    rd();
    chk("sime_read", bus.d_out, 8'h77);

    // Mid-operation async reset with 5 stored
    for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i));
    chk("pre_rst_empty", bus.empty, 0);
`ifdef FIFO_STATUS_EN
    chk("pre_rst_count", bus.count, 5);
`endif
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", bus.empty, 1);
    chk("arst_full",  bus.full, 0);
    chk("arst_dout",  bus.d_out, 8'h00);
`ifdef FIFO_STATUS_EN
    chk("arst_count", bus.count, 0);
    chk("arst_ovf",   bus.overflow, 0);
    chk("arst_uf",    bus.underflow, 0);
`endif
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_empty", bus.empty, 1);
    chk("post_rst_dout",  bus.d_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
